// File: rtl/fp6_pkg.sv
// Shared types for the FP6 adder front end: field widths, occupancy states,
// field extractors and the aligned-operand result record.
package fp6_pkg;

    localparam int FP6_EXP_W  = 2;
    localparam int FP6_MANT_W = 4;
    localparam int FP6_OP_W   = FP6_EXP_W + FP6_MANT_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    typedef logic [FP6_OP_W-1:0]   op_t;
    typedef logic [FP6_EXP_W-1:0]  exp_t;
    typedef logic [FP6_MANT_W-1:0] mant_t;

    typedef struct packed {
        mant_t mant_small;
        exp_t  shift_sel;
        mant_t mant_large;
        exp_t  exp_large;
        logic  swapped;
        logic  sticky;
    } res_t;

    function automatic exp_t op_exp(input op_t op);
        return op[FP6_OP_W-1:FP6_MANT_W];
    endfunction

    function automatic mant_t op_mant(input op_t op);
        return op[FP6_MANT_W-1:0];
    endfunction

endpackage

// File: rtl/fp6_operand_order.sv
// Combinational compare/swap of an operand pair plus exponent difference.
// Sticky (OR of bits the shifter will discard) is built only with FP6_STICKY_EN.
module fp6_operand_order
    import fp6_pkg::*;
(
    input  op_t  op_a,
    input  op_t  op_b,
    output res_t res
);

    exp_t  ea, eb, el, es;
    mant_t ma, mb;
    logic  b_big;

    always_comb begin
        ea = op_exp(op_a);
        eb = op_exp(op_b);
        ma = op_mant(op_a);
        mb = op_mant(op_b);
        // A full tie keeps A as the larger operand.
        b_big = (eb > ea) || ((eb == ea) && (mb > ma));
        el = b_big ? eb : ea;
        es = b_big ? ea : eb;

        res            = '0;
        res.swapped    = b_big;
        res.exp_large  = el;
        res.mant_large = b_big ? mb : ma;
        res.mant_small = b_big ? ma : mb;
        res.shift_sel  = el - es;
`ifdef FP6_STICKY_EN
        for (int i = 0; i < FP6_MANT_W; i++) begin
            if (i < int'(res.shift_sel))
                res.sticky = res.sticky | res.mant_small[i];
        end
`endif
    end

endmodule

// File: rtl/fp6_align_ctrl.sv
// Exponent-compare / operand-order stage: elastic valid/ready register with a
// one-entry skid buffer. Optional sticky output under FP6_STICKY_EN.
module fp6_align_ctrl
    import fp6_pkg::*;
#(
    parameter int EXP_W  = FP6_EXP_W,
    parameter int MANT_W = FP6_MANT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+MANT_W-1:0] op_a,
    input  logic [EXP_W+MANT_W-1:0] op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MANT_W-1:0]       mant_small,
    output logic [EXP_W-1:0]        shift_sel,
    output logic [MANT_W-1:0]       mant_large,
    output logic [EXP_W-1:0]        exp_large,
    output logic                    swapped
`ifdef FP6_STICKY_EN
    ,output logic                   sticky
`endif
);

    occ_t state;
    res_t nxt, out_r, skid_r;
    logic accept, drain;

    fp6_operand_order u_order (
        .op_a (op_a),
        .op_b (op_b),
        .res  (nxt)
    );

    // Ready comes from registered occupancy only, so no comb path from out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            out_r  <= '0;
            skid_r <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_r <= nxt;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        out_r <= nxt;
                    end else if (accept) begin
                        skid_r <= nxt;
                        state  <= FULL;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        out_r <= skid_r;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign mant_small = out_r.mant_small;
    assign shift_sel  = out_r.shift_sel;
    assign mant_large = out_r.mant_large;
    assign exp_large  = out_r.exp_large;
    assign swapped    = out_r.swapped;
`ifdef FP6_STICKY_EN
    assign sticky     = out_r.sticky;
`endif

endmodule

// File: tb/tb_fp6_align_ctrl.sv
// Self-checking bench for fp6_align_ctrl: directed vector table, skid/backpressure
// sequences, streaming and random-handshake scoreboard against a numeric model.
module tb_fp6_align_ctrl;

`ifdef FP6_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [5:0] op_a = '0, op_b = '0;
    logic       in_ready, out_valid, swapped, sticky;
    logic [3:0] mant_small, mant_large;
    logic [1:0] shift_sel, exp_large;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    fp6_align_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mant_small (mant_small),
        .shift_sel  (shift_sel),
        .mant_large (mant_large),
        .exp_large  (exp_large),
        .swapped    (swapped)
`ifdef FP6_STICKY_EN
        ,.sticky    (sticky)
`endif
    );
`ifndef FP6_STICKY_EN
    assign sticky = 1'b0;
`endif

    // Packed view {mant_small, shift_sel, mant_large, exp_large, swapped, sticky}
    function automatic logic [13:0] dut_out();
        return {mant_small, shift_sel, mant_large, exp_large, swapped, sticky};
    endfunction

    // Larger operand = larger 6-bit value, since exp sits above mant.
    function automatic logic [13:0] model(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] big, sml;
        int sh, ms;
        logic bl, st;
        bl  = (b > a);
        big = bl ? b : a;
        sml = bl ? a : b;
        sh  = int'(big[5:4]) - int'(sml[5:4]);
        ms  = int'(sml[3:0]);
        st  = STK && ((ms % (1 << sh)) != 0);
        return {sml[3:0], 2'(sh), big[3:0], big[5:4], bl, st};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the random-handshake phase
    logic        mon_en = 1'b0;
    logic        acc_n = 1'b0;
    logic [13:0] sb[$];

    always @(negedge clk) begin
        acc_n = in_valid && in_ready;
        if (mon_en) begin
            chk("sb_out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("sb_in_ready", 32'(in_ready), 32'(sb.size() < 2));
            if (out_valid && out_ready && sb.size() != 0)
                chk("sb_data", 32'(dut_out()), 32'(sb.pop_front()));
            if (in_valid && in_ready)
                sb.push_back(model(op_a, op_b));
        end
    end

    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic [13:0] exp;
    } vec_t;

    vec_t tv[6];
    logic [5:0] bt_a[3], bt_b[3];
    logic [5:0] pa, pb;

    initial begin
        tv[0] = '{6'b11_1010, 6'b01_0110, {4'b0110, 2'b10, 4'b1010, 2'b11, 1'b0, STK}};
        tv[1] = '{6'b00_0011, 6'b10_1000, {4'b0011, 2'b10, 4'b1000, 2'b10, 1'b1, STK}};
        tv[2] = '{6'b01_0101, 6'b01_0101, {4'b0101, 2'b00, 4'b0101, 2'b01, 1'b0, 1'b0}};
        tv[3] = '{6'b01_0100, 6'b01_0110, {4'b0100, 2'b00, 4'b0110, 2'b01, 1'b1, 1'b0}};
        tv[4] = '{6'b00_1111, 6'b11_0001, {4'b1111, 2'b11, 4'b0001, 2'b11, 1'b1, STK}};
        tv[5] = '{6'b11_0000, 6'b00_1000, {4'b1000, 2'b11, 4'b0000, 2'b11, 1'b0, 1'b0}};

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_data", 32'(dut_out()), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors, one beat at a time
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; op_a = tv[i].a; op_b = tv[i].b;
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), 32'(dut_out()), 32'(tv[i].exp));
            tick();
            chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: 3 beats offered, skid fills, then drain in order
        for (int i = 0; i < 3; i++) begin
            bt_a[i] = 6'($urandom); bt_b[i] = 6'($urandom);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; op_a = bt_a[0]; op_b = bt_b[0];
        tick();
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        chk("bp_b1", 32'(dut_out()), 32'(model(bt_a[0], bt_b[0])));
        op_a = bt_a[1]; op_b = bt_b[1];
        tick();
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        chk("bp_hold1", 32'(dut_out()), 32'(model(bt_a[0], bt_b[0])));
        op_a = bt_a[2]; op_b = bt_b[2];
        tick();
        chk("bp_rdy3", 32'(in_ready), 32'd0);
        chk("bp_hold2", 32'(dut_out()), 32'(model(bt_a[0], bt_b[0])));
        out_ready = 1'b1;
        tick();
        chk("bp_rdy_back", 32'(in_ready), 32'd1);
        chk("bp_out2", 32'(dut_out()), 32'(model(bt_a[1], bt_b[1])));
        tick();
        in_valid = 1'b0;
        chk("bp_out3_valid", 32'(out_valid), 32'd1);
        chk("bp_out3", 32'(dut_out()), 32'(model(bt_a[2], bt_b[2])));
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: one result per cycle, 1-cycle latency
        for (int i = 0; i <= 16; i++) begin
            in_valid = (i < 16);
            pa = op_a; pb = op_b;
            op_a = 6'($urandom); op_b = 6'($urandom);
            if (i > 0) begin
                chk($sformatf("st%0d_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("st%0d_rdy", i), 32'(in_ready), 32'd1);
                chk($sformatf("st%0d_data", i), 32'(dut_out()), 32'(model(pa, pb)));
            end
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Random handshakes against the scoreboard
        mon_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc_n) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op_a = 6'($urandom); op_b = 6'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        mon_en = 1'b0;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Async reset while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; op_a = 6'b11_1111; op_b = 6'b00_0001;
        tick();
        op_a = 6'b10_1011;
        tick();
        in_valid = 1'b0;
        chk("full_rdy", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd1);
        chk("arst_data", 32'(dut_out()), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        in_valid = 1'b1; op_a = 6'b01_0011; op_b = 6'b11_0010; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(dut_out()),
            32'({4'b0011, 2'b10, 4'b0010, 2'b11, 1'b1, STK}));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
